multi_band_centroid: RTL and testbench
======================================

MULTI_BAND_CENTROID -- requirements
Module: multi_band_centroid

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, image height in rows.
REQ-003 SHALL have parameter PIX_W, default 4, input pixel width.
REQ-004 SHALL have parameter NUM_BANDS, default 4, number of horizontal ROI bands, 1..8.
REQ-005 SHALL have parameter BAND_HEIGHT, default 32, rows per band; NUM_BANDS*BAND_HEIGHT <= IMG_H.
REQ-006 SHALL have parameter THRESHOLD, default 0; a pixel is "on" when pixel_in > THRESHOLD.
REQ-007 SHALL have parameter MIN_COUNT, default 1, minimum weight for a band to count as not lost.
REQ-008 SHALL have parameter MODE, default 0; 0 = binary (weight 1 per on-pixel), 1 = intensity-weighted (weight = pixel_in per on-pixel).
REQ-009 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-010 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pixel_in, input, PIX_W, raster-order pixel.
REQ-012 SHALL have port in_ready, input, 1, pixel_in valid this cycle.
REQ-013 SHALL have port sof, input, 1, synchronous frame restart strobe.
REQ-014 SHALL have port res_valid, output, 1, one-cycle strobe per band result.
REQ-015 SHALL have port res_band, output, $clog2(NUM_BANDS)+1, band index of current result.
REQ-016 SHALL have port res_x, output, $clog2(IMG_W)+1, band centroid column.
REQ-017 SHALL have port res_lost, output, 1, band weight < MIN_COUNT.
REQ-018 SHALL have port frame_done, output, 1, one-cycle strobe after last band result.
REQ-019 SHALL have port overrun, output, 1, one-cycle strobe when a frame end is dropped.

Function
REQ-020 Internal x/y counters SHALL advance only on in_ready; x wraps at IMG_W-1, y wraps at IMG_H-1.
REQ-021 Band k (0 = bottom) SHALL cover rows IMG_H-(k+1)*BAND_HEIGHT .. IMG_H-k*BAND_HEIGHT-1; rows outside all bands are ignored.
REQ-022 Per band, accumulators sum_w += weight and sum_xw += x*weight SHALL update on each accepted on-pixel; widths sized so IMG_W*BAND_HEIGHT*(2^PIX_W-1) pixels never overflow.
REQ-023 On acceptance of pixel (IMG_W-1, IMG_H-1) ("frame end"), all band accumulators SHALL be copied to snapshot registers and cleared in the same cycle.
REQ-024 sof SHALL zero x/y counters and clear accumulators; sof with in_ready in the same cycle SHALL count that pixel as (0,0); sof SHALL NOT disturb snapshot or divider.
REQ-025 FSM states IDLE, DIV, EMIT, DONE: IDLE->DIV on frame end (band 0); DIV->EMIT when quotient complete; EMIT->DIV (next band) or ->DONE after band NUM_BANDS-1; DONE->IDLE unconditionally.
REQ-026 DIV SHALL compute floor(sum_xw/sum_w) by restoring division, one quotient bit per cycle; band with sum_w < MIN_COUNT SHALL skip division, res_x=0, res_lost=1.
REQ-027 res_valid SHALL assert for exactly one cycle in EMIT with res_band, res_x, res_lost stable that cycle; bands emitted in order 0..NUM_BANDS-1.
REQ-028 frame_done SHALL assert for one cycle in DONE, the cycle after the last res_valid.
REQ-029 A frame end while FSM not IDLE SHALL pulse overrun, leave snapshot unchanged, and still clear accumulators.
REQ-030 res_x, res_lost, res_band SHALL hold their last values between strobes.

Reset
REQ-031 rst low SHALL immediately force counters, accumulators, snapshots, divider to 0, FSM to IDLE, and all outputs to 0, including mid-division.
REQ-032 After rst release, no res_valid SHALL occur before the first complete frame end.

Structure
REQ-033 Shared package SHALL hold the FSM state enum, width-derivation functions for accumulator/quotient widths, and MODE constants.
REQ-034 Division SHALL live in one sub-module seq_divider (start/busy/done handshake, parametrised width), instantiated once and shared across bands.

Verification (IMG_W=640, IMG_H=480, NUM_BANDS=4, BAND_HEIGHT=32, THRESHOLD=0, MIN_COUNT=1)
REQ-035 MODE=0, columns 318..321 =15 all rows, else 0 -> bands 0..3 each res_x=319, res_lost=0, then frame_done.
REQ-036 MODE=0, all-zero frame -> four results res_x=0, res_lost=1, frame_done, no overrun.
REQ-037 MODE=0, column 100 =15 only in rows 448..479 -> band 0 res_x=100, bands 1..3 res_lost=1.
REQ-038 MODE=1, rows 448..479 with x=10 value 15 and x=20 value 5 -> band 0 res_x=12.
REQ-039 sof after 1000 pixels of noise, then clean frame of REQ-035 -> results identical to REQ-035.
REQ-040 rst low during DIV of band 1 -> all outputs 0 at once; no res_valid until next full frame end, which yields correct results.

Source files
------------

// File: rtl/multi_band_centroid_pkg.sv
// rtl/multi_band_centroid_pkg.sv - shared FSM type, mode constants and width helpers
//
// Purpose: common definitions for multi_band_centroid and its divider.
// Contents:
//   state_t        - result sequencer states (IDLE, DIV, EMIT, DONE)
//   MODE_*         - pixel weighting modes
//   sum_w_width    - bits needed for a band's weight sum
//   sum_xw_width   - bits needed for a band's x*weight sum
//   quot_width     - bits of the reported centroid column
package multi_band_centroid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int MODE_BINARY    = 0;
  localparam int MODE_INTENSITY = 1;

  // Smallest width (at least 1) that can hold the given non-negative value.
  function automatic int bits_for(input longint value);
    int n;
    n = 1;
    while ((longint'(1) << n) <= value) n++;
    return n;
  endfunction

  // Worst case: every pixel of a band is on at full scale.
  function automatic int sum_w_width(input int img_w, input int band_h, input int pix_w);
    return bits_for(longint'(img_w) * longint'(band_h) * ((longint'(1) << pix_w) - 1));
  endfunction

  // Worst case: the full-scale weight sum all sitting in the last column.
  function automatic int sum_xw_width(input int img_w, input int band_h, input int pix_w);
    return bits_for(longint'(img_w) * longint'(band_h) * ((longint'(1) << pix_w) - 1)
                    * longint'(img_w - 1));
  endfunction

  function automatic int quot_width(input int img_w);
    return $clog2(img_w) + 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle
//
// Purpose: computes floor(dividend / divisor) in N_W cycles after start.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   start           - load operands and begin (ignored while busy)
//   dividend        - N_W-bit numerator
//   divisor         - D_W-bit denominator
//   busy            - division in progress
//   done            - one-cycle strobe, quotient valid this cycle
//   quotient        - N_W-bit result
module seq_divider #(
  parameter int N_W = 8,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient
);

  localparam int C_W = $clog2(N_W + 1);

  logic [D_W-1:0] rem;
  // Holds the remaining dividend bits at the top while quotient bits shift in below.
  logic [N_W-1:0] quo;
  logic [C_W-1:0] cnt;
  logic [D_W:0]   trial;

  assign trial    = {rem, quo[N_W-1]};
  assign quotient = quo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo  <= dividend;
        rem  <= '0;
        cnt  <= C_W'(N_W);
        busy <= 1'b1;
      end else if (busy) begin
        if (trial >= {1'b0, divisor}) begin
          rem <= D_W'(trial - {1'b0, divisor});
          quo <= {quo[N_W-2:0], 1'b1};
        end else begin
          rem <= trial[D_W-1:0];
          quo <= {quo[N_W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == C_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_band_centroid.sv
// rtl/multi_band_centroid.sv - per-band horizontal centroid of a raster frame
//
// Purpose: accumulates on-pixel weight and x*weight for NUM_BANDS horizontal
// bands counted up from the bottom of the frame, snapshots them at frame end
// and reports floor(sum_xw/sum_w) per band through one shared divider.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   pixel_in     - raster-order pixel, accepted when in_ready is high
//   in_ready     - pixel_in valid this cycle
//   sof          - restart the frame; a pixel accepted with it is (0,0)
//   res_valid    - one-cycle strobe per band result
//   res_band     - band index of the current result
//   res_x        - centroid column of that band
//   res_lost     - band weight below MIN_COUNT
//   frame_done   - one-cycle strobe after the last band result
//   overrun      - one-cycle strobe when a frame end arrived while busy
module multi_band_centroid
  import multi_band_centroid_pkg::*;
#(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int PIX_W       = 4,
  parameter int NUM_BANDS   = 4,
  parameter int BAND_HEIGHT = 32,
  parameter int THRESHOLD   = 0,
  parameter int MIN_COUNT   = 1,
  parameter int MODE        = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PIX_W-1:0]               pixel_in,
  input  logic                           in_ready,
  input  logic                           sof,
  output logic                           res_valid,
  output logic [$clog2(NUM_BANDS):0]     res_band,
  output logic [$clog2(IMG_W):0]         res_x,
  output logic                           res_lost,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam int X_W   = $clog2(IMG_W);
  localparam int Y_W   = $clog2(IMG_H);
  localparam int RB_W  = $clog2(NUM_BANDS) + 1;
  localparam int RX_W  = quot_width(IMG_W);
  localparam int SW_W  = sum_w_width(IMG_W, BAND_HEIGHT, PIX_W);
  localparam int SXW_W = sum_xw_width(IMG_W, BAND_HEIGHT, PIX_W);
  localparam logic [SW_W-1:0] MIN_W = SW_W'(MIN_COUNT);

  logic [X_W-1:0]   x_cnt, x_eff;
  logic [Y_W-1:0]   y_cnt, y_eff;
  logic             x_last, y_last, frame_end, pix_on;
  logic [SW_W-1:0]  weight;
  logic [SXW_W-1:0] xw;
  logic [NUM_BANDS-1:0] in_band;

  logic [SW_W-1:0]  acc_w   [NUM_BANDS];
  logic [SXW_W-1:0] acc_xw  [NUM_BANDS];
  logic [SW_W-1:0]  nxt_w   [NUM_BANDS];
  logic [SXW_W-1:0] nxt_xw  [NUM_BANDS];
  logic [SW_W-1:0]  snap_w  [NUM_BANDS];
  logic [SXW_W-1:0] snap_xw [NUM_BANDS];

  state_t           state, state_n;
  logic [RB_W-1:0]  band;
  logic [SW_W-1:0]  sel_w;
  logic [SXW_W-1:0] sel_xw;
  logic             sel_lost, sel_skip;
  logic             res_load, div_start, div_busy, div_done;
  logic [SXW_W-1:0] div_q;

  // sof makes the current cycle's pixel position (0,0) before anything else.
  assign x_eff     = sof ? '0 : x_cnt;
  assign y_eff     = sof ? '0 : y_cnt;
  assign x_last    = (x_eff == X_W'(IMG_W - 1));
  assign y_last    = (y_eff == Y_W'(IMG_H - 1));
  assign frame_end = in_ready && x_last && y_last;
  assign pix_on    = (pixel_in > PIX_W'(THRESHOLD));

  always_comb begin
    weight = '0;
    if (in_ready && pix_on) begin
      case (MODE)
        MODE_BINARY:    weight = SW_W'(1);
        MODE_INTENSITY: weight = SW_W'(pixel_in);
        default:        weight = SW_W'(1);
      endcase
    end
    xw = SXW_W'(x_eff) * SXW_W'(weight);
  end

  // Band 0 is the bottom BAND_HEIGHT rows; higher bands stack upwards.
  always_comb begin
    in_band = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      in_band[k] = (int'(y_eff) >= IMG_H - (k + 1) * BAND_HEIGHT) &&
                   (int'(y_eff) <= IMG_H - k * BAND_HEIGHT - 1);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BANDS; k++) begin
      nxt_w[k]  = (sof ? '0 : acc_w[k])  + (in_band[k] ? weight : '0);
      nxt_xw[k] = (sof ? '0 : acc_xw[k]) + (in_band[k] ? xw : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_ready) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_eff + 1'b1;
      end else begin
        x_cnt <= x_eff + 1'b1;
        y_cnt <= y_eff;
      end
    end else if (sof) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  // The frame-end pixel itself belongs to the snapshot. A frame end while the
  // sequencer is busy still restarts accumulation but keeps the old snapshot,
  // which the divider may be reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        acc_w[k]   <= '0;
        acc_xw[k]  <= '0;
        snap_w[k]  <= '0;
        snap_xw[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        if (frame_end) begin
          acc_w[k]  <= '0;
          acc_xw[k] <= '0;
          if (state == ST_IDLE) begin
            snap_w[k]  <= nxt_w[k];
            snap_xw[k] <= nxt_xw[k];
          end
        end else begin
          acc_w[k]  <= nxt_w[k];
          acc_xw[k] <= nxt_xw[k];
        end
      end
    end
  end

  always_comb begin
    sel_w  = '0;
    sel_xw = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (band == RB_W'(k)) begin
        sel_w  = snap_w[k];
        sel_xw = snap_xw[k];
      end
    end
    sel_lost = (sel_w < MIN_W);
    // An empty band is never divided, even if MIN_COUNT would allow it.
    sel_skip = sel_lost || (sel_w == '0);
  end

  seq_divider #(
    .N_W (SXW_W),
    .D_W (SW_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sel_xw),
    .divisor  (sel_w),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // In DIV, a divider that is neither busy nor done means this band has not
  // been launched yet.
  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    res_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_end) state_n = ST_DIV;
      end
      ST_DIV: begin
        if (!div_busy && !div_done) begin
          if (sel_skip) begin
            res_load = 1'b1;
            state_n  = ST_EMIT;
          end else begin
            div_start = 1'b1;
          end
        end else if (div_done) begin
          res_load = 1'b1;
          state_n  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        state_n = (band == RB_W'(NUM_BANDS - 1)) ? ST_DONE : ST_DIV;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      band     <= '0;
      res_band <= '0;
      res_x    <= '0;
      res_lost <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= frame_end && (state != ST_IDLE);
      if (state == ST_IDLE && frame_end) begin
        band <= '0;
      end else if (state == ST_EMIT && state_n == ST_DIV) begin
        band <= band + 1'b1;
      end
      if (res_load) begin
        res_band <= band;
        res_x    <= sel_skip ? '0 : div_q[RX_W-1:0];
        res_lost <= sel_lost;
      end
    end
  end

  assign res_valid  = (state == ST_EMIT);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_multi_band_centroid.sv
// tb/tb_multi_band_centroid.sv - self-checking bench for multi_band_centroid
module tb_multi_band_centroid;

  localparam int W = 40, H = 48, NB = 4, BH = 4;
  localparam int W2 = 4, H2 = 4, NB2 = 2, BH2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] pixel_in = '0;
  logic in_ready = 1'b0, sof = 1'b0;
  logic [3:0] pix2 = '0;
  logic rdy2 = 1'b0, sof2 = 1'b0;

  logic rv0, rl0, fd0, ov0, rv1, rl1, fd1, ov1, rv2, rl2, fd2, ov2;
  logic [2:0] rb0, rb1;
  logic [6:0] rx0, rx1;
  logic [1:0] rb2;
  logic [2:0] rx2;

  always #5 clk = ~clk;

  multi_band_centroid #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .NUM_BANDS(NB), .BAND_HEIGHT(BH),
                        .THRESHOLD(0), .MIN_COUNT(1), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready), .sof(sof),
    .res_valid(rv0), .res_band(rb0), .res_x(rx0), .res_lost(rl0),
    .frame_done(fd0), .overrun(ov0));

  multi_band_centroid #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .NUM_BANDS(NB), .BAND_HEIGHT(BH),
                        .THRESHOLD(0), .MIN_COUNT(1), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready), .sof(sof),
    .res_valid(rv1), .res_band(rb1), .res_x(rx1), .res_lost(rl1),
    .frame_done(fd1), .overrun(ov1));

  multi_band_centroid #(.IMG_W(W2), .IMG_H(H2), .PIX_W(4), .NUM_BANDS(NB2), .BAND_HEIGHT(BH2),
                        .THRESHOLD(0), .MIN_COUNT(1), .MODE(0)) dut2 (
    .clk(clk), .rst(rst), .pixel_in(pix2), .in_ready(rdy2), .sof(sof2),
    .res_valid(rv2), .res_band(rb2), .res_x(rx2), .res_lost(rl2),
    .frame_done(fd2), .overrun(ov2));

  int errors = 0, checks = 0, cyc = 0;
  int done0 = 0, done1 = 0, done2 = 0, ovr0 = 0, ovr1 = 0, ovr2 = 0;
  int lastv0 = 0, lastv1 = 0, fdc0 = 0, fdc1 = 0;
  int q0[$], q1[$], q2[$];
  int img[H][W];
  int exp2[NB2];

  function automatic int pack(input int b, input int x, input int l);
    return b * 65536 + x * 2 + l;
  endfunction

  // Reference: sum the band's rows straight from the stored image.
  function automatic int model(input int mode, input int k, input int w, input int h, input int bh);
    int sw, sxw, wt;
    sw = 0; sxw = 0;
    for (int y = h - (k + 1) * bh; y <= h - k * bh - 1; y++)
      for (int x = 0; x < w; x++)
        if (img[y][x] > 0) begin
          wt = (mode == 1) ? img[y][x] : 1;
          sw += wt;
          sxw += x * wt;
        end
    if (sw < 1) return pack(k, 0, 1);
    return pack(k, sxw / sw, 0);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rv0) begin q0.push_back(pack(int'(rb0), int'(rx0), int'(rl0))); lastv0 = cyc; end
    if (rv1) begin q1.push_back(pack(int'(rb1), int'(rx1), int'(rl1))); lastv1 = cyc; end
    if (rv2) q2.push_back(pack(int'(rb2), int'(rx2), int'(rl2)));
    if (fd0) begin done0++; fdc0 = cyc; end
    if (fd1) begin done1++; fdc1 = cyc; end
    if (fd2) done2++;
    if (ov0) ovr0++;
    if (ov1) ovr1++;
    if (ov2) ovr2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gaps, input bit with_sof);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gaps)
          while ($urandom_range(0, 3) == 0) begin
            in_ready = 1'b0; pixel_in = 4'($urandom); sof = 1'b0; tick();
          end
        pixel_in = 4'(img[y][x]);
        in_ready = 1'b1;
        sof = with_sof && (y == 0) && (x == 0);
        tick();
      end
    in_ready = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_small();
    for (int y = 0; y < H2; y++)
      for (int x = 0; x < W2; x++) begin
        pix2 = 4'(img[y][x]);
        rdy2 = 1'b1;
        tick();
      end
    rdy2 = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input int b0, input int b1);
    int t, got;
    t = 0;
    while (!(done0 > b0 && done1 > b1) && t < 4000) begin tick(); t++; end
    check({tag, "_timeout"}, 32'(t < 4000), 1);
    check({tag, "_count_m0"}, q0.size(), NB);
    check({tag, "_count_m1"}, q1.size(), NB);
    for (int k = 0; k < NB; k++) begin
      got = (q0.size() > 0) ? q0.pop_front() : -1;
      check($sformatf("%s_b%0d_m0", tag, k), got, model(0, k, W, H, BH));
      got = (q1.size() > 0) ? q1.pop_front() : -1;
      check($sformatf("%s_b%0d_m1", tag, k), got, model(1, k, W, H, BH));
    end
    check({tag, "_done_after_last_m0"}, fdc0, lastv0 + 1);
    check({tag, "_done_after_last_m1"}, fdc1, lastv1 + 1);
    check({tag, "_no_overrun"}, ovr0 + ovr1, 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic fill_random(input int zero_band);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
    if (zero_band >= 0)
      for (int y = H - (zero_band + 1) * BH; y <= H - zero_band * BH - 1; y++)
        for (int x = 0; x < W; x++) img[y][x] = 0;
  endtask

  task automatic fill_cols();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = (x >= 18 && x <= 21) ? 15 : 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_res_valid"}, 32'(rv0), 0);
    check({tag, "_res_band"}, 32'(rb0), 0);
    check({tag, "_res_x"}, 32'(rx0), 0);
    check({tag, "_res_lost"}, 32'(rl0), 0);
    check({tag, "_frame_done"}, 32'(fd0), 0);
    check({tag, "_overrun"}, 32'(ov0), 0);
  endtask

  initial begin
    int b0, b1, b2, t, got;

    // Reset state
    repeat (2) tick();
    check_outputs_zero("reset");
    check("reset_m1_res_valid", 32'(rv1), 0);
    check("reset_small_res_valid", 32'(rv2), 0);
    rst = 1'b1;
    tick();

    // Four bright columns 18..21 in every row
    fill_cols();
    b0 = done0; b1 = done1;
    send_frame(0, 0);
    expect_frame("cols", b0, b1);

    // All-zero frame
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;
    b0 = done0; b1 = done1;
    send_frame(0, 0);
    expect_frame("zero", b0, b1);

    // Single column 10 in band 0 only
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = (x == 10 && y >= H - BH) ? 15 : 0;
    b0 = done0; b1 = done1;
    send_frame(0, 0);
    expect_frame("col10", b0, b1);

    // Intensity weighting: x=10 at 15, x=20 at 5 in band 0
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (y >= H - BH) ? ((x == 10) ? 15 : (x == 20) ? 5 : 0) : 0;
    b0 = done0; b1 = done1;
    send_frame(0, 0);
    expect_frame("intensity", b0, b1);

    // 1000 noise pixels, then sof on the first pixel of a clean frame
    for (int i = 0; i < 1000; i++) begin
      pixel_in = 4'($urandom); in_ready = 1'b1; tick();
    end
    in_ready = 1'b0;
    fill_cols();
    b0 = done0; b1 = done1;
    send_frame(0, 1);
    expect_frame("sof_clean", b0, b1);

    // Random frame with stalls
    fill_random(-1);
    b0 = done0; b1 = done1;
    send_frame(1, 0);
    expect_frame("rand1", b0, b1);

    // Gappy noise, lone sof without a pixel, then random frame with an empty band
    for (int i = 0; i < 300; i++) begin
      pixel_in = 4'($urandom); in_ready = 1'($urandom); tick();
    end
    in_ready = 1'b0; sof = 1'b1; tick(); sof = 1'b0;
    fill_random(2);
    b0 = done0; b1 = done1;
    send_frame(1, 0);
    expect_frame("rand2", b0, b1);

    // Reset asserted while band 1 is being divided
    fill_cols();
    b0 = done0;
    send_frame(0, 0);
    t = 0;
    while (q0.size() == 0 && t < 3000) begin tick(); t++; end
    check("midreset_band0_seen", 32'(t < 3000), 1);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1 check_outputs_zero("midreset");
    tick();
    tick();
    rst = 1'b1;
    q0.delete(); q1.delete();
    b0 = done0; b1 = done1;
    repeat (60) tick();
    check("midreset_quiet_results", q0.size() + q1.size(), 0);
    check("midreset_quiet_done", done0, b0);
    send_frame(0, 0);
    expect_frame("after_reset", b0, b1);

    // Small instance: back-to-back frames force an overrun on the second
    for (int y = 0; y < H2; y++) for (int x = 0; x < W2; x++) img[y][x] = int'($urandom_range(1, 15));
    for (int k = 0; k < NB2; k++) exp2[k] = model(0, k, W2, H2, BH2);
    b2 = done2;
    send_small();
    for (int y = 0; y < H2; y++) for (int x = 0; x < W2; x++) img[y][x] = int'($urandom_range(1, 15));
    send_small();
    t = 0;
    while (done2 == b2 && t < 500) begin tick(); t++; end
    check("ovr_timeout", 32'(t < 500), 1);
    repeat (40) tick();
    check("ovr_single_done", done2, b2 + 1);
    check("ovr_pulse_count", ovr2, 1);
    check("ovr_result_count", q2.size(), NB2);
    for (int k = 0; k < NB2; k++) begin
      got = (q2.size() > 0) ? q2.pop_front() : -1;
      check($sformatf("ovr_keep_b%0d", k), got, exp2[k]);
    end
    q2.delete();

    // The dropped frame must not leak into the next one
    for (int y = 0; y < H2; y++) for (int x = 0; x < W2; x++) img[y][x] = int'($urandom_range(0, 15));
    b2 = done2;
    send_small();
    t = 0;
    while (done2 == b2 && t < 500) begin tick(); t++; end
    check("post_ovr_timeout", 32'(t < 500), 1);
    check("post_ovr_result_count", q2.size(), NB2);
    for (int k = 0; k < NB2; k++) begin
      got = (q2.size() > 0) ? q2.pop_front() : -1;
      check($sformatf("post_ovr_b%0d", k), got, model(0, k, W2, H2, BH2));
    end
    check("post_ovr_no_new_overrun", ovr2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
